output_arbiter: RTL and testbench
=================================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 The block SHALL have parameter PORTS, default 5: number of requesting input ports, range 2..8.
REQ-002 The block SHALL have parameter PORT_BITS, default 3: width of the grant index; 2**PORT_BITS >= PORTS.
REQ-003 The block SHALL have parameter TIMEOUT, default 64: maximum hold cycles per grant; only used with the timeout feature; must be >= 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port sw_req, input, PORTS bits: per-port request; bit i high while rx unit i wants the shared output channel.
REQ-007 The block SHALL have port out_ready, input, 1 bit: downstream channel can accept a new packet.
REQ-008 The block SHALL have port sw_gnt, output, PORTS bits: one-hot (or zero) registered grant.
REQ-009 The block SHALL have port sw_sel, output, PORT_BITS bits: index of the current owner; drives the crossbar mux select.
REQ-010 The block SHALL have port busy, output, 1 bit: high while any grant is held.
REQ-011 The block SHALL have port timeout_err, output, 1 bit: single-cycle pulse on forced revoke; constant 0 when the feature is compiled out.

Function
REQ-012 The block SHALL implement two states: IDLE and GRANT.
REQ-013 IDLE -> GRANT SHALL occur when (sw_req != 0) and out_ready = 1 at the clock edge; otherwise the block stays in IDLE.
- On that transition, sw_gnt is set to the one-hot winner, sw_sel to its index, and busy to 1, all valid in the following cycle.
REQ-014 The winner SHALL be the first requesting port found scanning upward from ptr+1, modulo PORTS, wrapping through ptr itself last.
- ptr is the index of the last released owner.
REQ-015 In GRANT, sw_gnt and sw_sel SHALL hold constant while sw_req[owner] = 1.
- Requests from other ports and changes on out_ready are ignored during GRANT.
REQ-016 GRANT -> IDLE SHALL occur on the edge where sw_req[owner] = 0.
- On that edge: sw_gnt is cleared, busy is cleared, and ptr is set to the owner index.
- sw_sel retains its last value.
REQ-017 Exactly one IDLE cycle SHALL separate consecutive grants; back-to-back grants are prohibited.
REQ-018 With a single persistent requester k, successive grants SHALL all go to k.
REQ-019 With all ports requesting continuously, grant order SHALL be strictly cyclic: 0, 1, ..., PORTS-1, 0, ...
REQ-020 Request bits at index >= PORTS SHALL NOT exist; sw_sel SHALL never exceed PORTS-1.
REQ-021 Latency from request to grant SHALL be 1 cycle, given IDLE, out_ready = 1, and the requester is the round-robin winner.

Reset
REQ-022 While reset = 0 at a clock edge, the block SHALL load the following on that edge:
- state = IDLE
- sw_gnt = 0, sw_sel = 0, busy = 0, timeout_err = 0
- ptr = PORTS-1 (so port 0 wins first)
- timeout counter = 0
REQ-023 Reset asserted during GRANT SHALL revoke the grant on that same edge, with no partial-state retention.
REQ-024 Outputs SHALL be X-free from the first edge with reset = 0.

Configuration
REQ-025 When macro OUTPUT_ARBITER_TIMEOUT_EN is defined, the block SHALL count cycles spent in GRANT, starting at 0 on entry.
- When the count reaches TIMEOUT-1 with sw_req[owner] still 1, the next edge forces GRANT -> IDLE, sets ptr = owner, and pulses timeout_err for 1 cycle.
- The revoked port may be re-granted later in round-robin order.
REQ-026 When OUTPUT_ARBITER_TIMEOUT_EN is undefined, the block SHALL hold a grant indefinitely and tie timeout_err to 0, with no counter logic present.

Verification
REQ-027 Reset and first grant: reset low for 2 cycles, then sw_req = 5'b00100 with out_ready = 1 -> sw_gnt = 5'b00100 and sw_sel = 2 one cycle later, with busy = 1.
REQ-028 Fairness: sw_req = 5'b11111 held, each owner dropping its request for 1 cycle after 3 grant cycles -> grant order 0, 1, 2, 3, 4, 0, with 1 IDLE cycle between each.
REQ-029 Backpressure: out_ready = 0 and sw_req = 5'b00010 for 10 cycles -> sw_gnt stays 0; out_ready rises -> grant to port 1 on the next edge.
REQ-030 Wrap-around: last owner 4, then sw_req = 5'b10001 -> port 0 granted, not port 4.
REQ-031 Mid-grant reset: port 3 owns the grant, reset pulled low for 1 cycle -> sw_gnt = 0 and busy = 0 at that edge; afterwards sw_req = 5'b11000 -> port 3 granted (ptr = 4 after reset).
REQ-032 Timeout (macro defined, TIMEOUT = 8): port 2 holds sw_req high forever -> sw_gnt[2] high for exactly 8 cycles, timeout_err = 1 for 1 cycle, then the next requester in order is served.

Source files
------------

// File: rtl/output_arbiter_if.sv
// Request/grant bundle between the rx units, the downstream channel and the output arbiter.
// master: arbiter side (consumes requests, drives grants). slave: requester/environment side.
interface output_arbiter_if #(
    parameter int unsigned PORTS     = 5,
    parameter int unsigned PORT_BITS = 3
);
    logic [PORTS-1:0]     sw_req;
    logic                 out_ready;
    logic [PORTS-1:0]     sw_gnt;
    logic [PORT_BITS-1:0] sw_sel;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        input  sw_req,
        input  out_ready,
        output sw_gnt,
        output sw_sel,
        output busy,
        output timeout_err
    );

    modport slave (
        output sw_req,
        output out_ready,
        input  sw_gnt,
        input  sw_sel,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/output_arbiter.sv
// Round-robin arbiter for one shared output channel.
// A grant is held until the owner drops its request; one IDLE cycle always separates grants.
// Optional feature: define OUTPUT_ARBITER_TIMEOUT_EN to revoke grants held for TIMEOUT cycles
// and pulse timeout_err; otherwise grants are held indefinitely and timeout_err is tied low.
module output_arbiter #(
    parameter int unsigned PORTS     = 5,
    parameter int unsigned PORT_BITS = 3,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    output_arbiter_if.master bus
);
    // Requests padded to the full index range so any PORT_BITS index is a legal select.
    localparam int unsigned Slots = 2 ** PORT_BITS;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e               state_q, state_d;
    logic [PORTS-1:0]     gnt_q, gnt_d;
    logic [PORT_BITS-1:0] sel_q, sel_d;
    logic [PORT_BITS-1:0] ptr_q, ptr_d;
    logic                 busy_q, busy_d;

`ifdef OUTPUT_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tout_q, tout_d;
`endif

    logic [Slots-1:0]     req_ext;
    logic [Slots-1:0]     one_hot;
    logic                 win_found;
    logic [PORT_BITS-1:0] win_idx;
    logic [PORT_BITS-1:0] idx;
    int                   cand;

    // Round-robin pick: first requester above ptr, wrapping, with ptr itself checked last.
    always_comb begin
        req_ext   = '0;
        req_ext[PORTS-1:0] = bus.sw_req;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        cand      = 0;
        // Scan from the farthest offset down so the nearest requester is assigned last.
        for (int i = int'(PORTS); i >= 1; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= int'(PORTS)) begin
                cand = cand - int'(PORTS);
            end
            idx = PORT_BITS'(cand);
            if (req_ext[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Next-state logic for the IDLE/GRANT controller.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        one_hot = Slots'(1) << win_idx;
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.out_ready && win_found) begin
                    state_d = StGrant;
                    gnt_d   = one_hot[PORTS-1:0];
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StGrant: begin
                // sel_q keeps its value on release so the crossbar select stays stable.
                if (!req_ext[sel_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q;
                end
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset; ptr resets so port 0 wins first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= PORT_BITS'(PORTS - 1);
            busy_q  <= 1'b0;
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign bus.sw_gnt = gnt_q;
    assign bus.sw_sel = sel_q;
    assign bus.busy   = busy_q;
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
    assign bus.timeout_err = tout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: expected grant ports are queued as requests are driven and
// popped when the arbiter issues a grant. Inputs change and outputs are sampled on negedge.
module tb_output_arbiter;
    localparam int unsigned PORTS     = 5;
    localparam int unsigned PORT_BITS = 3;

    logic clk;
    logic reset;

    output_arbiter_if #(.PORTS(PORTS), .PORT_BITS(PORT_BITS)) bus ();

    output_arbiter #(
        .PORTS    (PORTS),
        .PORT_BITS(PORT_BITS),
        .TIMEOUT  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    // Waits (bounded) for a nonzero grant; returns zeros if none appears.
    task automatic wait_grant(input int budget, output logic [4:0] g, output logic [2:0] s,
                              output int cyc);
        bit done;
        done = 1'b0;
        g    = '0;
        s    = '0;
        cyc  = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.sw_gnt != 5'b0) begin
                g    = bus.sw_gnt;
                s    = bus.sw_sel;
                done = 1'b1;
            end
        end
        if (!done) cyc = budget + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        bus.sw_req     = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.sw_gnt, bus.sw_sel, bus.busy, bus.timeout_err} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: got gnt=%b sel=%0d busy=%b terr=%b, want all 0",
                     bus.sw_gnt, bus.sw_sel, bus.busy, bus.timeout_err);
        end
        reset = 1'b1;
    endtask

    task automatic test_first_grant();
        logic [4:0] g;
        logic [2:0] s;
        int cyc;
        int exp;
        bus.sw_req    = 5'b00100;
        bus.out_ready = 1'b1;
        exp_q.push_back(2);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp) || cyc !== 1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: got gnt=%b sel=%0d lat=%0d busy=%b, want gnt=%b sel=%0d lat=1 busy=1",
                     g, s, cyc, bus.busy, 5'(1 << exp), exp);
        end
        bus.sw_req = '0;
        @(negedge clk);
        n_tests++;
        if (bus.sw_gnt !== 5'b0 || bus.busy !== 1'b0 || bus.sw_sel !== 3'd2) begin
            n_fail++;
            $display("FAIL release: got gnt=%b busy=%b sel=%0d, want gnt=0 busy=0 sel=2",
                     bus.sw_gnt, bus.busy, bus.sw_sel);
        end
    endtask

    task automatic test_fairness();
        logic [4:0] g;
        logic [2:0] s;
        int cyc;
        int exp;
        do_reset();
        bus.sw_req    = 5'b11111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(k % 5);
            wait_grant(5, g, s, cyc);
            exp = exp_q.pop_front();
            n_tests++;
            if (g !== 5'(1 << exp) || s !== 3'(exp) || cyc !== 1) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: got gnt=%b sel=%0d lat=%0d, want gnt=%b sel=%0d lat=1",
                         k, g, s, cyc, 5'(1 << exp), exp);
            end
            repeat (2) begin
                @(negedge clk);
                n_tests++;
                if (bus.sw_gnt !== 5'(1 << exp)) begin
                    n_fail++;
                    $display("FAIL fair_hold[%0d]: got gnt=%b, want %b", k, bus.sw_gnt,
                             5'(1 << exp));
                end
            end
            bus.sw_req = 5'b11111 & ~5'(1 << exp);
            @(negedge clk);
            n_tests++;
            if (bus.sw_gnt !== 5'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL fair_idle[%0d]: got gnt=%b busy=%b, want gnt=0 busy=0",
                         k, bus.sw_gnt, bus.busy);
            end
            bus.sw_req = (k == 5) ? 5'b0 : 5'b11111;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [4:0] g;
        logic [2:0] s;
        int cyc;
        int exp;
        int bad;
        bad           = 0;
        bus.out_ready = 1'b0;
        bus.sw_req    = 5'b00010;
        repeat (10) begin
            @(negedge clk);
            if (bus.sw_gnt !== 5'b0 || bus.busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %0d cycles with a grant, want 0", bad);
        end
        bus.out_ready = 1'b1;
        exp_q.push_back(1);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp) || cyc !== 1) begin
            n_fail++;
            $display("FAIL backpressure_grant: got gnt=%b sel=%0d lat=%0d, want gnt=%b sel=%0d lat=1",
                     g, s, cyc, 5'(1 << exp), exp);
        end
        bus.sw_req = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [4:0] g;
        logic [2:0] s;
        int cyc;
        int exp;
        bus.sw_req = 5'b10000;
        exp_q.push_back(4);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp)) begin
            n_fail++;
            $display("FAIL wrap_setup: got gnt=%b sel=%0d, want gnt=%b sel=%0d", g, s,
                     5'(1 << exp), exp);
        end
        bus.sw_req = '0;
        @(negedge clk);
        bus.sw_req = 5'b10001;
        exp_q.push_back(0);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp) || cyc !== 1) begin
            n_fail++;
            $display("FAIL wrap_grant: got gnt=%b sel=%0d lat=%0d, want gnt=%b sel=%0d lat=1",
                     g, s, cyc, 5'(1 << exp), exp);
        end
        bus.sw_req = '0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [4:0] g;
        logic [2:0] s;
        int cyc;
        int exp;
        bus.sw_req = 5'b01000;
        exp_q.push_back(3);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp)) begin
            n_fail++;
            $display("FAIL midreset_setup: got gnt=%b sel=%0d, want gnt=%b sel=%0d", g, s,
                     5'(1 << exp), exp);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.sw_gnt !== 5'b0 || bus.busy !== 1'b0 || bus.sw_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_revoke: got gnt=%b busy=%b sel=%0d, want 0 0 0",
                     bus.sw_gnt, bus.busy, bus.sw_sel);
        end
        reset      = 1'b1;
        bus.sw_req = 5'b11000;
        exp_q.push_back(3);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp) || cyc !== 1) begin
            n_fail++;
            $display("FAIL midreset_regrant: got gnt=%b sel=%0d lat=%0d, want gnt=%b sel=%0d lat=1",
                     g, s, cyc, 5'(1 << exp), exp);
        end
        bus.sw_req = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [4:0] g;
        logic [2:0] s;
        int cyc;
        int exp;
        int bad;
        bus.sw_req = 5'b00010;
        exp_q.push_back(1);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp)) begin
            n_fail++;
            $display("FAIL b2b_first: got gnt=%b sel=%0d, want gnt=%b sel=%0d", g, s,
                     5'(1 << exp), exp);
        end
        bad           = 0;
        bus.sw_req    = 5'b11111;
        bus.out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.sw_gnt !== 5'b00010 || bus.sw_sel !== 3'd1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_hold: got %0d cycles with changed grant, want 0", bad);
        end
        bus.sw_req    = 5'b11101;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.sw_gnt !== 5'b0 || bus.busy !== 1'b0 || bus.sw_sel !== 3'd1) begin
            n_fail++;
            $display("FAIL b2b_idle: got gnt=%b busy=%b sel=%0d, want gnt=0 busy=0 sel=1",
                     bus.sw_gnt, bus.busy, bus.sw_sel);
        end
        exp_q.push_back(2);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp) || cyc !== 1) begin
            n_fail++;
            $display("FAIL b2b_next: got gnt=%b sel=%0d lat=%0d, want gnt=%b sel=%0d lat=1",
                     g, s, cyc, 5'(1 << exp), exp);
        end
        bus.sw_req = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [4:0] g;
        logic [2:0] s;
        int cyc;
        int exp;
        int held;
        bus.sw_req = 5'b00100;
        exp_q.push_back(2);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp)) begin
            n_fail++;
            $display("FAIL timeout_setup: got gnt=%b sel=%0d, want gnt=%b sel=%0d", g, s,
                     5'(1 << exp), exp);
        end
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
        bus.sw_req = 5'b10100;
        held       = 1;
        while (bus.sw_gnt === 5'b00100 && held < 30) begin
            @(negedge clk);
            if (bus.sw_gnt === 5'b00100) held++;
        end
        n_tests++;
        if (held !== 8 || bus.timeout_err !== 1'b1 || bus.sw_gnt !== 5'b0) begin
            n_fail++;
            $display("FAIL timeout_revoke: got held=%0d terr=%b gnt=%b, want held=8 terr=1 gnt=0",
                     held, bus.timeout_err, bus.sw_gnt);
        end
        exp_q.push_back(4);
        wait_grant(5, g, s, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if (g !== 5'(1 << exp) || s !== 3'(exp) || cyc !== 1 || bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_next: got gnt=%b sel=%0d lat=%0d terr=%b, want gnt=%b sel=%0d lat=1 terr=0",
                     g, s, cyc, bus.timeout_err, 5'(1 << exp), exp);
        end
`else
        held = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.sw_gnt !== 5'b00100 || bus.timeout_err !== 1'b0) held++;
        end
        n_tests++;
        if (held != 0) begin
            n_fail++;
            $display("FAIL no_timeout_hold: got %0d bad cycles, want 0", held);
        end
`endif
        bus.sw_req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
